fsm_rr_arbiter: RTL and testbench

- Round-robin arbiter FSM that shares one downstream resource (a shared FSM datapath or output channel) among N requesters.
- Grants exactly one requester at a time, holds the grant while its request stays high, and optionally force-releases after a bounded tenure.
- Sits between the requester FSMs and the shared resource; all outputs are registered.

---
 rtl/fsm_rr_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_fsm_rr_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fsm_rr_arbiter
//
// Purpose:
//   Round-robin arbiter that shares one downstream resource among N requester
//   FSMs. Exactly one requester owns the resource at a time. The owner keeps
//   its grant while its request stays high. Ownership then passes to the next
//   requester in circular order, starting after the last owner. No idle cycle
//   is inserted when another requester is waiting.
//
//   Optional feature (macro FSM_ARB_TIMEOUT_EN):
//     When the macro is defined, a tenure is force-released after MAX_HOLD
//     consecutive grant cycles. The new grant may go back to the same owner if
//     it is the only requester. On the cycle that new grant appears, preempt
//     pulses for one cycle. When the macro is undefined, the tenure counter
//     is not built and preempt is tied low.
//
// Parameters:
//   N        number of requesters (2..16)
//   MAX_HOLD maximum consecutive grant cycles per tenure (timeout build only)
//   IDW      width of gnt_id, must be >= clog2(N)
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-low reset
//   req      in   [N]   request vector, bit i = requester i wants the resource
//   gnt      out  [N]   one-hot grant vector, all zero when idle (registered)
//   gnt_id   out  [IDW] index of current owner, 0 when idle (registered)
//   busy     out  high while any grant is asserted (registered)
//   preempt  out  one-cycle pulse with the first grant after a forced release
//
// Every output comes straight from a flop. There is no combinational path
// from req to any output.
// -----------------------------------------------------------------------------
module fsm_rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           preempt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // State and registered outputs
    state_t         state_q,   state_d;
    logic [N-1:0]   gnt_q,     gnt_d;
    logic [IDW-1:0] gnt_id_q,  gnt_id_d;
    logic           busy_q,    busy_d;
    logic           preempt_q, preempt_d;
    // In BUSY, ptr_q holds the current owner. In IDLE, it holds the last owner.
    logic [IDW-1:0] ptr_q,     ptr_d;

`ifdef FSM_ARB_TIMEOUT_EN
    localparam int HCW = $clog2(MAX_HOLD + 1);
    logic [HCW-1:0] hold_q, hold_d;
`endif

    // -------------------------------------------------------------------------
    // Winner search: candidates are ptr+1, ptr+2, ... ptr+N (mod N).
    // The pointer itself is the last candidate. This one search covers all
    // three cases:
    //   - arbitration from IDLE,
    //   - voluntary release, where req[owner] is already low and cannot win,
    //   - forced release, where the owner may win again as the last candidate.
    // The loop runs from lowest to highest priority, so the final assignment
    // that fires is the winner.
    // -------------------------------------------------------------------------
    logic           found;
    logic [IDW-1:0] win_id;
    logic [N-1:0]   win_onehot;

    always_comb begin
        int idx;
        found  = 1'b0;
        win_id = '0;
        idx    = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr_q) + k) % N;
            if (req[idx]) begin
                found  = 1'b1;
                win_id = IDW'(idx);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign win_onehot[gi] = found && (win_id == IDW'(gi));
        end
    endgenerate

    // The current owner's request. This is only meaningful in BUSY.
    logic owner_req;
    assign owner_req = req[ptr_q];

    // -------------------------------------------------------------------------
    // Next-state / next-output logic
    // -------------------------------------------------------------------------
    logic do_grant;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        busy_d    = busy_q;
        ptr_d     = ptr_q;
        preempt_d = 1'b0;
        do_grant  = 1'b0;
`ifdef FSM_ARB_TIMEOUT_EN
        hold_d    = hold_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    do_grant = 1'b1;
                end
            end

            ST_BUSY: begin
                if (owner_req) begin
`ifdef FSM_ARB_TIMEOUT_EN
                    if (hold_q == HCW'(MAX_HOLD)) begin
                        // Forced release. found is guaranteed because the
                        // owner itself is still requesting.
                        do_grant  = 1'b1;
                        preempt_d = 1'b1;
                    end else begin
                        hold_d = hold_q + HCW'(1);
                    end
`endif
                end else if (found) begin
                    // Voluntary release, direct handoff with no idle gap
                    do_grant = 1'b1;
                end else begin
                    // Voluntary release with nobody waiting. ptr_q keeps the
                    // last owner so it has lowest priority next time.
                    state_d  = ST_IDLE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    busy_d   = 1'b0;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
            end
        endcase

        if (do_grant) begin
            state_d  = ST_BUSY;
            gnt_d    = win_onehot;
            gnt_id_d = win_id;
            busy_d   = 1'b1;
            ptr_d    = win_id;
`ifdef FSM_ARB_TIMEOUT_EN
            hold_d   = HCW'(1);
`endif
        end
    end

    // -------------------------------------------------------------------------
    // State register. The pointer resets to N-1, so requester 0 has first
    // priority after reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
            ptr_q     <= IDW'(N - 1);
`ifdef FSM_ARB_TIMEOUT_EN
            hold_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
            ptr_q     <= ptr_d;
`ifdef FSM_ARB_TIMEOUT_EN
            hold_q    <= hold_d;
`endif
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;

`ifdef FSM_ARB_TIMEOUT_EN
    assign preempt = preempt_q;
`else
    // Without the timeout the pulse can never fire. The flop is kept so that
    // both builds share the same FSM body; synthesis removes it.
    logic unused_preempt;
    assign unused_preempt = preempt_q;
    assign preempt        = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fsm_rr_arbiter
//
// Scoreboard bench for fsm_rr_arbiter with N=4 and MAX_HOLD=4.
//
// The stimulus process drives req on the falling edge. A reference model
// applies the arbitration rules at every rising edge and queues the expected
// outputs for that cycle. The model tracks owner, last owner and tenure
// length as plain integers.
//
// A monitor pops the queue 1 ns after each rising edge and compares the
// queued entry with the DUT outputs. The directed test-plan scenarios also
// carry a few fixed-value checks.
// -----------------------------------------------------------------------------
module tb_fsm_rr_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
    localparam int IDW      = 2;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           preempt;

    fsm_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .IDW(IDW)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .preempt (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    // Expected outputs packed as {gnt[3:0], gnt_id[1:0], busy, preempt}
    logic [7:0] exp_q[$];

    // ---------------- reference model ----------------
    int m_owner = -1;       // -1 = nobody holds the resource
    int m_last  = N - 1;    // last owner (lowest priority)
    int m_ten   = 0;        // grant cycles in the current tenure
    bit m_pre   = 1'b0;

    // First requester found going round the ring after 'last'. 'last' itself
    // is checked last.
    function automatic int search(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_pack();
        logic [3:0] g;
        logic [1:0] id;
        g  = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        id = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        return {g, id, (m_owner >= 0), m_pre};
    endfunction

    task automatic model_step(input logic [N-1:0] r);
        int w;
        m_pre = 1'b0;
        if (m_owner < 0) begin
            w = search(r, m_last);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_ten = 1;
            end
        end else if (r[m_owner]) begin
`ifdef FSM_ARB_TIMEOUT_EN
            if (m_ten >= MAX_HOLD) begin
                w = search(r, m_owner);
                m_owner = w; m_last = w; m_ten = 1; m_pre = 1'b1;
            end else begin
                m_ten++;
            end
`else
            m_ten++;
`endif
        end else begin
            w = search(r, m_owner);
            m_owner = w;
            if (w >= 0) begin
                m_last = w; m_ten = 1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_owner = -1; m_last = N - 1; m_ten = 0; m_pre = 1'b0;
            end else begin
                model_step(req);
                exp_q.push_back(model_pack());
            end
        end
    end

    // ---------------- comparison ----------------
    task automatic check(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = {gnt, gnt_id, busy, preempt};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d req=%b: got gnt=%b id=%0d busy=%b pre=%b, expected gnt=%b id=%0d busy=%b pre=%b",
                     name, cyc, req, act[7:4], act[3:2], act[1], act[0],
                     exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    // Monitor: one comparison per clocked cycle out of reset
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                #1;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL scoreboard_empty cyc=%0d: got no expected entry, required one", cyc);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    $display("cyc %0d req=%b gnt=%b id=%0d busy=%b pre=%b", cyc, req, gnt, gnt_id, busy, preempt);
                    check("scoreboard", e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic hold(input logic [N-1:0] r, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req = r;
        end
    endtask

    task automatic async_reset_pulse();
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check("async_reset_clear", 8'b0000_00_0_0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Reset mid-grant, then the first grant after release
        hold(4'b1111, 3);
        async_reset_pulse();
        req = 4'b1111;
        @(posedge clk);
        #1 check("first_grant", 8'b0001_00_1_0);

        // Fairness between two requesters
        hold(4'b0000, 2);
        hold(4'b1010, 16);

        // Sole requester
        hold(4'b0000, 2);
        hold(4'b0001, 10);

        // Voluntary handoff from owner 1 to requester 2
        hold(4'b0000, 2);
        hold(4'b0010, 1);
        hold(4'b0110, 1);
        hold(4'b0100, 1);
        @(posedge clk);
        #1 check("voluntary_handoff", 8'b0100_10_1_0);

        // Idle, then regrant to requester 3
        hold(4'b0000, 1);
        @(posedge clk);
        #1 check("go_idle", 8'b0000_00_0_0);
        hold(4'b1000, 1);
        @(posedge clk);
        #1 check("regrant_3", 8'b1000_11_1_0);

        // Long full request, then drop requester 0
        hold(4'b0000, 2);
        async_reset_pulse();
        hold(4'b1111, 20);
        hold(4'b1110, 3);

        // Random traffic. Request patterns are held for a while so that
        // tenures run long, and a reset is injected now and then.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset_pulse();
            end else if ($urandom_range(0, 9) < 3) begin
                hold(4'($urandom_range(0, 15)), 1);
            end else begin
                hold(req, 1);
            end
        end

        hold(4'b0000, 3);
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
